serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 107 ++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions for the serial subtractor: controller state encodings
// and the default operand width.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between the ALU operand bus and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero
  );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock; operands and
// result each cross a valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready high
// ST_SHIFT | one difference bit per cycle, WIDTH cycles total
// ST_DONE  | result held with out_valid high until out_ready
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             zero_q, zero_d;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] diff_shifted;

  full_subtractor_bit u_fsb (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign diff_shifted = {bit_d, diff_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = bit_bout;
        diff_d = diff_shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        // zero is latched with the final bit so it is stable for all of DONE
        if (cnt_q == CNT_LAST) begin
          zero_d  = (diff_shifted == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = br_q;
  assign bus.zero      = zero_q;

endmodule
